// File: rtl/cam_power_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cam_power_sequencer                                             |
// | Purpose  : OV5642 power-up / reset sequencer. Walks the sensor through     |
// |            power-down, hardware reset and settle, launches SCCB register   |
// |            configuration and flags the video path ready once it is done.   |
// |            A rising edge on the debounced restart input re-runs the whole  |
// |            sequence without a system reset.                                |
// | Options  : `define CAM_SEQ_RETRY_EN to retry a failed configuration up to  |
// |            CFG_RETRIES times before declaring a fault.                     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module cam_power_sequencer #(
  parameter int PWDN_CYCLES        = 100_000,
  parameter int RSTB_CYCLES        = 100_000,
  parameter int SETTLE_CYCLES      = 2_000_000,
  parameter int CFG_TIMEOUT_CYCLES = 10_000_000,
  parameter int CNT_W              = 24,
  parameter int CFG_RETRIES        = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_restart,
  input  logic       i_cfg_done,
  input  logic       i_cfg_err,
  output logic       o_cam_pwdn,
  output logic       o_cam_rstn,
  output logic       o_cfg_start,
  output logic       o_ready,
  output logic       o_busy,
  output logic       o_fault,
  output logic [2:0] o_state
);

  // Reject meaningless timing/retry settings at elaboration.
  if (PWDN_CYCLES < 1 || RSTB_CYCLES < 1 || SETTLE_CYCLES < 1 ||
      CFG_TIMEOUT_CYCLES < 1 || CFG_RETRIES < 0) begin : g_bad_params
    $error("cam_power_sequencer: cycle parameters must be >= 1, CFG_RETRIES >= 0");
  end

  typedef enum logic [2:0] {
    ST_PWDN      = 3'd0,
    ST_RSTB      = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_CFG_START = 3'd3,
    ST_CFG_WAIT  = 3'd4,
    ST_READY     = 3'd5,
    ST_FAULT     = 3'd6
  } state_t;

  // Last counter value of each timed state: the state exits on that edge.
  localparam logic [CNT_W-1:0] c_pwdn_last   = CNT_W'(PWDN_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_rstb_last   = CNT_W'(RSTB_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_settle_last = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_tmo_last    = CNT_W'(CFG_TIMEOUT_CYCLES - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_restart_q;
  logic             w_restart_rise;
  logic             w_fail;

`ifdef CAM_SEQ_RETRY_EN
  localparam int                 c_rty_w   = (CFG_RETRIES < 1) ? 1 : $clog2(CFG_RETRIES + 1);
  localparam logic [c_rty_w-1:0] c_rty_max = c_rty_w'(CFG_RETRIES);
  logic [c_rty_w-1:0]            r_rty_cnt;
`endif

  // The edge-detect register resets high so a button held through reset is not a restart.
  assign w_restart_rise = i_restart & ~r_restart_q;

  // Next-state decision; restart overrides every other condition.
  always_comb begin
    w_next = r_state;
    w_fail = 1'b0;
    if (w_restart_rise) begin
      w_next = ST_PWDN;
    end else begin
      case (r_state)
        ST_PWDN:      if (r_cnt == c_pwdn_last)   w_next = ST_RSTB;
        ST_RSTB:      if (r_cnt == c_rstb_last)   w_next = ST_SETTLE;
        ST_SETTLE:    if (r_cnt == c_settle_last) w_next = ST_CFG_START;
        ST_CFG_START: w_next = ST_CFG_WAIT;
        ST_CFG_WAIT: begin
          // Error beats a simultaneous done; timeout only if done is absent.
          if (i_cfg_err || (!i_cfg_done && r_cnt == c_tmo_last)) begin
            w_fail = 1'b1;
          end else if (i_cfg_done) begin
            w_next = ST_READY;
          end
        end
        ST_READY:     w_next = ST_READY;
        ST_FAULT:     w_next = ST_FAULT;
        default:      w_next = ST_PWDN;
      endcase
      if (w_fail) begin
`ifdef CAM_SEQ_RETRY_EN
        w_next = (r_rty_cnt < c_rty_max) ? ST_PWDN : ST_FAULT;
`else
        w_next = ST_FAULT;
`endif
      end
    end
  end

  // State, delay counter and outputs all register on the same edge, outputs decoded from next state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_PWDN;
      r_cnt       <= '0;
      r_restart_q <= 1'b1;
      o_cam_pwdn  <= 1'b1;
      o_cam_rstn  <= 1'b0;
      o_cfg_start <= 1'b0;
      o_ready     <= 1'b0;
      o_busy      <= 1'b1;
      o_fault     <= 1'b0;
      o_state     <= 3'd0;
`ifdef CAM_SEQ_RETRY_EN
      r_rty_cnt   <= '0;
`endif
    end else begin
      r_restart_q <= i_restart;
      r_state     <= w_next;
      // Counter restarts on every state entry (including a restart into PWDN) and freezes when idle.
      if (w_restart_rise || (w_next != r_state)) begin
        r_cnt <= '0;
      end else if (r_state != ST_READY && r_state != ST_FAULT) begin
        r_cnt <= r_cnt + 1'b1;
      end
      o_cam_pwdn  <= (w_next == ST_PWDN) || (w_next == ST_FAULT);
      o_cam_rstn  <= (w_next == ST_SETTLE) || (w_next == ST_CFG_START) ||
                     (w_next == ST_CFG_WAIT) || (w_next == ST_READY);
      o_cfg_start <= (w_next == ST_CFG_START);
      o_ready     <= (w_next == ST_READY);
      o_fault     <= (w_next == ST_FAULT);
      o_busy      <= (w_next != ST_READY) && (w_next != ST_FAULT);
      o_state     <= w_next;
`ifdef CAM_SEQ_RETRY_EN
      if (w_restart_rise || (w_next == ST_READY)) begin
        r_rty_cnt <= '0;
      end else if (w_fail && (w_next == ST_PWDN)) begin
        r_rty_cnt <= r_rty_cnt + 1'b1;
      end
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cam_power_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_cam_power_sequencer                                          |
// | Purpose  : Self-checking bench for cam_power_sequencer. A timeline model   |
// |            (elapsed clocks since sequence start plus a terminal outcome)   |
// |            predicts every output each cycle; directed scenarios are        |
// |            followed by a randomized phase.                                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_cam_power_sequencer;

  localparam int P  = 4;
  localparam int R  = 3;
  localparam int S  = 5;
  localparam int T  = 20;
  localparam int NR = 2;

  logic       clk     = 1'b0;
  logic       rst     = 1'b0;
  logic       restart = 1'b1;
  logic       done    = 1'b0;
  logic       err     = 1'b0;
  logic       pwdn, rstn, start, ready, busy, fault;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;

  // Reference model: m_e = clocks elapsed in the current sequence, m_term = 0 / 5 / 6
  int m_e;
  int m_term;
  int m_rty;
  bit m_prev;

  cam_power_sequencer #(
    .PWDN_CYCLES        (P),
    .RSTB_CYCLES        (R),
    .SETTLE_CYCLES      (S),
    .CFG_TIMEOUT_CYCLES (T),
    .CNT_W              (8),
    .CFG_RETRIES        (NR)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_restart   (restart),
    .i_cfg_done  (done),
    .i_cfg_err   (err),
    .o_cam_pwdn  (pwdn),
    .o_cam_rstn  (rstn),
    .o_cfg_start (start),
    .o_ready     (ready),
    .o_busy      (busy),
    .o_fault     (fault),
    .o_state     (state)
  );

  always #5 clk = ~clk;

  function automatic int exp_state();
    if (m_term != 0)      return m_term;
    if (m_e < P)          return 0;
    if (m_e < P + R)      return 1;
    if (m_e < P + R + S)  return 2;
    if (m_e == P + R + S) return 3;
    return 4;
  endfunction

  task automatic model_reset();
    m_e    = 0;
    m_term = 0;
    m_rty  = 0;
    m_prev = 1'b1;
  endtask

  // Advance the model across one clock edge using the inputs currently applied.
  task automatic model_edge();
    int s;
    bit rise;
    s      = exp_state();
    rise   = restart && !m_prev;
    m_prev = restart;
    if (rise) begin
      m_e    = 0;
      m_term = 0;
      m_rty  = 0;
    end else if (m_term != 0) begin
      m_term = m_term;
    end else if (s == 4) begin
      if (err || (!done && m_e == P + R + S + T)) begin
`ifdef CAM_SEQ_RETRY_EN
        if (m_rty < NR) begin
          m_rty = m_rty + 1;
          m_e   = 0;
        end else begin
          m_term = 6;
        end
`else
        m_term = 6;
`endif
      end else if (done) begin
        m_term = 5;
        m_rty  = 0;
      end else begin
        m_e = m_e + 1;
      end
    end else begin
      m_e = m_e + 1;
    end
  endtask

  task automatic chk(string where, string tag, logic [7:0] obs, logic [7:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s:%s observed=%0d expected=%0d", where, tag, obs, expv);
    end
  endtask

  task automatic check_outputs(string where);
    int s;
    s = exp_state();
    chk(where, "state", {5'd0, state}, 8'(s));
    chk(where, "pwdn",  {7'd0, pwdn},  {7'd0, (s == 0 || s == 6)});
    chk(where, "rstn",  {7'd0, rstn},  {7'd0, (s >= 2 && s <= 5)});
    chk(where, "start", {7'd0, start}, {7'd0, (s == 3)});
    chk(where, "ready", {7'd0, ready}, {7'd0, (s == 5)});
    chk(where, "busy",  {7'd0, busy},  {7'd0, (s <= 4)});
    chk(where, "fault", {7'd0, fault}, {7'd0, (s == 6)});
  endtask

  task automatic tick(string where);
    if (!rst) model_edge();
    @(posedge clk);
    #1;
    check_outputs(where);
  endtask

  task automatic run_to(int s, string where, int budget);
    int n;
    n = 0;
    while (exp_state() != s && n < budget) begin
      tick(where);
      n++;
    end
  endtask

  task automatic do_restart(string where);
    restart = 1'b0;
    tick({where, "_low"});
    restart = 1'b1;
    tick(where);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    check_outputs("reset");
    tick("reset_hold");
    tick("reset_hold");

    // Restart held high through reset release; stray done during PWDN ignored.
    rst = 1'b0;
    model_reset();
    tick("pwdn");
    done = 1'b1;
    tick("stray_done");
    done = 1'b0;

    // Nominal bring-up: done arrives 3 clocks after the cfg_start pulse.
    run_to(3, "seq1", 50);
    repeat (3) tick("seq1_wait");
    done = 1'b1;
    tick("seq1_ready");
    done = 1'b0;
    tick("seq1_hold");

    // Restart from READY, then again mid-SETTLE.
    do_restart("restart_ready");
    run_to(2, "seq2", 50);
    tick("seq2_settle");
    tick("seq2_settle");
    do_restart("restart_settle");
    run_to(3, "seq3", 50);
    tick("seq3_wait");
    done = 1'b1;
    tick("seq3_ready");
    done = 1'b0;

    // Configuration timeout (with retries when enabled).
    do_restart("restart_tmo");
    run_to(6, "timeout", 200);
    repeat (3) tick("fault_hold");

    // Simultaneous error and done in CFG_WAIT.
    do_restart("restart_err");
    run_to(4, "err_seq", 50);
    tick("err_wait");
    done = 1'b1;
    err  = 1'b1;
    tick("err_done");
    done = 1'b0;
    err  = 1'b0;
    run_to(6, "err_fault", 200);

    // Asynchronous reset mid-RSTB, between clock edges.
    do_restart("restart_async");
    run_to(1, "async_seq", 50);
    tick("async_rstb");
    #3 rst = 1'b1;
    model_reset();
    #1;
    check_outputs("async_rst");
    @(posedge clk);
    #1;
    check_outputs("async_rst_edge");
    rst = 1'b0;

    // Randomized traffic on all control inputs.
    for (int i = 0; i < 2000; i++) begin
      done = ($urandom_range(0, 7) == 0);
      err  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 59) == 0) restart = ~restart;
      tick("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
